writeresponse: RTL and testbench
================================

Name: writeresponse

Overview:
- Reverse-direction companion of the command-read path. Drains bytes from the shared response register, which is filled by the command processing state machines, and writes them into the external response FIFO.
- The FIFO has an active-low write strobe and an active-low full flag.
- Timing basis: 40 MHz clock (25 ns), 25 ns rated FIFO. The FIFO latches data on the rising (deasserting) edge of its write strobe.

Parameters:
- WR_PULSE_CYCLES, 2: cycles the write strobe is held low (≥1). The default gives 50 ns.
- HOLD_CYCLES, 1: cycles data is held after the strobe rises (≥1) before a new byte may be taken.

Ports:
- clk  in  1  system clock, 40 MHz
- nrst  in  1  reset; asynchronous, active-low
- nff  in  1  FIFO full flag, active-low (0 = full)
- disp_resp_wr  out  1  FIFO write strobe, active-low
- disp_resp_out  out  8  data to FIFO
- respreg_data_avail  in  1  shared response register holds a byte
- respreg_data_in  in  8  shared response register data output
- respreg_rd  out  1  one-cycle pulse that consumes (empties) the shared register
- busy  out  1  high whenever state != READY

Behaviour:
- Reset (async, nrst=0): disp_resp_wr=1, respreg_rd=0, disp_resp_out=8'h00, busy=0, state=READY, counters cleared.
  - Reset mid-write forces the strobe high immediately.
  - The in-flight byte is dropped; no partial-write recovery.
- States: READY, TAKE_REG, WRITE_PULSE, WRITE_HOLD. Width is 2 bits; encodings are fixed constants.
- READY:
  - Stays in READY unless respreg_data_avail=1 and nff=1, both sampled in the same cycle.
  - When both hold: disp_resp_out <= respreg_data_in, respreg_rd <= 1, go to TAKE_REG.
- TAKE_REG:
  - respreg_rd <= 0, so the pulse is exactly 1 cycle.
  - disp_resp_wr <= 0. Data has been stable for ≥1 cycle of setup before the strobe falls.
  - Load the pulse counter with WR_PULSE_CYCLES-1 and go to WRITE_PULSE.
- WRITE_PULSE:
  - Decrement the counter each cycle.
  - When the counter is 0: disp_resp_wr <= 1, load the hold counter with HOLD_CYCLES-1, go to WRITE_HOLD.
- WRITE_HOLD:
  - disp_resp_out stays unchanged.
  - When the counter is 0, go to READY.
- Latency and throughput:
  - Strobe falls 2 cycles after the qualifying READY sample.
  - Minimum byte period = 2 + WR_PULSE_CYCLES + HOLD_CYCLES cycles (5 at defaults).
- Full flag:
  - nff is checked only in READY. The FIFO guarantees a byte accepted while not full.
  - The full flag updating after the strobe rises is covered by the recheck in READY.
  - nff going low mid-write is ignored.
- Data-avail dropping in TAKE_REG or later: ignored, since data is already latched.
- disp_resp_out changes only on the READY→TAKE_REG transition and on reset.
- disp_resp_wr is never low outside TAKE_REG→WRITE_PULSE. It is always registered, so it is glitch-free.
- Counter width is clog2 of max(WR_PULSE_CYCLES, HOLD_CYCLES), minimum 1 bit.

Optional Feature:
- Macro: WRITERESPONSE_BYTE_COUNT_EN.
- When defined:
  - Adds output resp_byte_count [15:0].
  - Increments by 1 on each strobe rising edge (WRITE_PULSE→WRITE_HOLD) and wraps 16'hFFFF→0.
  - Reset value 0, cleared asynchronously by nrst.
  - A byte dropped by reset mid-write is not counted.
- When undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encodings
  - FIFO_FULL/FIFO_NOT_FULL flag constants
  - RESET_ASSERTED constant
  - timing defaults (WR_PULSE_CYCLES, HOLD_CYCLES), shared with the command-read side
- No sub-module. The pulse/hold down-counter stays inline; it is too small to justify a separate module.

Test Plan:
- Single byte, defaults:
  - Stimulus: avail=1, data_in=8'hA5, nff=1 in READY.
  - Required: respreg_rd high 1 cycle; disp_resp_wr low exactly 2 cycles starting 2 cycles after the sample; disp_resp_out=A5 stable from TAKE_REG through WRITE_HOLD; back in READY after 5 cycles.
- FIFO full:
  - Stimulus: avail=1, nff=0 for 10 cycles, then nff=1.
  - Required: no respreg_rd and no strobe while nff=0; write starts on the first cycle nff=1 is sampled.
- Back-to-back:
  - Stimulus: avail held 1, data 01,02,03 presented after each rd pulse.
  - Required: three strobes with data in order; strobe falls exactly 5 cycles apart.
- Reset during WRITE_PULSE:
  - Stimulus: nrst low asynchronously mid-strobe.
  - Required: disp_resp_wr=1 immediately, before the next clk edge; outputs at reset values; count (if enabled) not incremented.
- Parameters WR_PULSE_CYCLES=1, HOLD_CYCLES=3:
  - Required: 1-cycle strobe, 3-cycle hold, 6-cycle byte period.
- With WRITERESPONSE_BYTE_COUNT_EN:
  - Stimulus: preload scenario drives 65536 writes.
  - Required: resp_byte_count wraps to 0; it reads 3 after scenario 3 run from reset.

Source files
------------

// File: rtl/writeresponse_pkg.sv
// rtl/writeresponse_pkg.sv - shared constants for the response write path
// Purpose: state encodings, FIFO flag levels, reset level and timing defaults
//          shared between the command-read and response-write sides.
// Ports:   none (package).
package writeresponse_pkg;

  typedef enum logic [1:0] {
    ST_READY       = 2'b00,
    ST_TAKE_REG    = 2'b01,
    ST_WRITE_PULSE = 2'b10,
    ST_WRITE_HOLD  = 2'b11
  } wr_state_t;

  // FIFO full flag is active-low.
  localparam logic FIFO_FULL     = 1'b0;
  localparam logic FIFO_NOT_FULL = 1'b1;

  localparam logic RESET_ASSERTED = 1'b0;

  // 2 cycles at 40 MHz = 50 ns strobe; 1 cycle of data hold after it rises.
  localparam int DEF_WR_PULSE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES     = 1;

endpackage

// File: rtl/writeresponse.sv
// rtl/writeresponse.sv - drains the shared response register into the response FIFO
// Purpose: takes one byte from the shared response register whenever it holds
//          data and the FIFO is not full, then drives a registered active-low
//          write strobe of WR_PULSE_CYCLES followed by HOLD_CYCLES of data hold.
// Optional: WRITERESPONSE_BYTE_COUNT_EN adds resp_byte_count, a wrapping count
//           of completed strobes.
// Ports:
//   clk                 in   system clock (40 MHz)
//   nrst                in   asynchronous active-low reset
//   nff                 in   FIFO full flag, active-low
//   disp_resp_wr        out  FIFO write strobe, active-low
//   disp_resp_out       out  [7:0] data to FIFO
//   respreg_data_avail  in   shared response register holds a byte
//   respreg_data_in     in   [7:0] shared response register data
//   respreg_rd          out  one-cycle pulse consuming the shared register
//   busy                out  high whenever not in READY
//   resp_byte_count     out  [15:0] completed writes (optional)
module writeresponse
  import writeresponse_pkg::*;
#(
  parameter int WR_PULSE_CYCLES = DEF_WR_PULSE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        nff,
  output logic        disp_resp_wr,
  output logic [7:0]  disp_resp_out,
  input  logic        respreg_data_avail,
  input  logic [7:0]  respreg_data_in,
  output logic        respreg_rd,
`ifdef WRITERESPONSE_BYTE_COUNT_EN
  output logic [15:0] resp_byte_count,
`endif
  output logic        busy
);

  localparam int MAX_CYC = (WR_PULSE_CYCLES > HOLD_CYCLES) ? WR_PULSE_CYCLES : HOLD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] PULSE_LOAD = CW'(WR_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

  wr_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (nrst == RESET_ASSERTED) begin
      state         <= ST_READY;
      cnt           <= '0;
      disp_resp_wr  <= 1'b1;
      disp_resp_out <= 8'h00;
      respreg_rd    <= 1'b0;
    end else begin
      case (state)
        ST_READY: begin
          // nff is only examined here; a byte committed to the strobe is
          // always accepted by the FIFO.
          if (respreg_data_avail && (nff == FIFO_NOT_FULL)) begin
            disp_resp_out <= respreg_data_in;
            respreg_rd    <= 1'b1;
            state         <= ST_TAKE_REG;
          end
        end
        ST_TAKE_REG: begin
          // Data has been on the bus for one cycle, giving setup before the fall.
          respreg_rd   <= 1'b0;
          disp_resp_wr <= 1'b0;
          cnt          <= PULSE_LOAD;
          state        <= ST_WRITE_PULSE;
        end
        ST_WRITE_PULSE: begin
          if (cnt == '0) begin
            disp_resp_wr <= 1'b1;
            cnt          <= HOLD_LOAD;
            state        <= ST_WRITE_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WRITE_HOLD: begin
          if (cnt == '0) begin
            state <= ST_READY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state        <= ST_READY;
          disp_resp_wr <= 1'b1;
          respreg_rd   <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_READY);

`ifdef WRITERESPONSE_BYTE_COUNT_EN
  // Counts on the strobe's rising edge only, so a write cut short by reset
  // is never counted.
  always_ff @(posedge clk or negedge nrst) begin
    if (nrst == RESET_ASSERTED) begin
      resp_byte_count <= 16'h0000;
    end else if (state == ST_WRITE_PULSE && cnt == '0) begin
      resp_byte_count <= resp_byte_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_writeresponse.sv
// tb/tb_writeresponse.sv - directed self-checking bench for writeresponse
module tb_writeresponse;

  logic        clk = 1'b0;
  logic        nrst;
  logic        nff, avail;
  logic [7:0]  din;
  logic        wr, rd, busy;
  logic [7:0]  dout;
  logic        nff2, avail2;
  logic [7:0]  din2;
  logic        wr2, rd2, busy2;
  logic [7:0]  dout2;
`ifdef WRITERESPONSE_BYTE_COUNT_EN
  logic [15:0] cnt1, cnt2;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int fall_t[3];

  always #12.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  writeresponse u_dut (
    .clk(clk), .nrst(nrst), .nff(nff),
    .disp_resp_wr(wr), .disp_resp_out(dout),
    .respreg_data_avail(avail), .respreg_data_in(din),
    .respreg_rd(rd),
`ifdef WRITERESPONSE_BYTE_COUNT_EN
    .resp_byte_count(cnt1),
`endif
    .busy(busy)
  );

  writeresponse #(.WR_PULSE_CYCLES(1), .HOLD_CYCLES(3)) u_p13 (
    .clk(clk), .nrst(nrst), .nff(nff2),
    .disp_resp_wr(wr2), .disp_resp_out(dout2),
    .respreg_data_avail(avail2), .respreg_data_in(din2),
    .respreg_rd(rd2),
`ifdef WRITERESPONSE_BYTE_COUNT_EN
    .resp_byte_count(cnt2),
`endif
    .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  initial begin
    nrst = 1'b1; nff = 1'b1; avail = 1'b0; din = 8'h00;
    nff2 = 1'b1; avail2 = 1'b0; din2 = 8'h00;
    #3;
    nrst = 1'b0;
    #1;
    check("rst_wr", {15'd0, wr}, 16'd1);
    check("rst_rd", {15'd0, rd}, 16'd0);
    check("rst_out", {8'd0, dout}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    tick();
    nrst = 1'b1;
    tick();

    // Single byte at defaults
    avail = 1'b1; din = 8'hA5;
    tick();                                   // qualifying sample
    check("s1_rd_hi", {15'd0, rd}, 16'd1);
    check("s1_out", {8'd0, dout}, 16'h00A5);
    check("s1_wr_hi_take", {15'd0, wr}, 16'd1);
    check("s1_busy", {15'd0, busy}, 16'd1);
    avail = 1'b0; din = 8'hFF;
    tick();
    check("s1_rd_lo", {15'd0, rd}, 16'd0);
    check("s1_wr_lo1", {15'd0, wr}, 16'd0);
    tick();
    check("s1_wr_lo2", {15'd0, wr}, 16'd0);
    check("s1_out_pulse", {8'd0, dout}, 16'h00A5);
    tick();
    check("s1_wr_rise", {15'd0, wr}, 16'd1);
    check("s1_busy_hold", {15'd0, busy}, 16'd1);
    check("s1_out_hold", {8'd0, dout}, 16'h00A5);
    tick();
    check("s1_ready", {15'd0, busy}, 16'd0);

    // FIFO full: nothing happens until nff returns high
    nff = 1'b0; avail = 1'b1; din = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s2_no_rd", {15'd0, rd}, 16'd0);
      check("s2_no_wr", {15'd0, wr}, 16'd1);
    end
    nff = 1'b1;
    tick();
    check("s2_rd", {15'd0, rd}, 16'd1);
    check("s2_out", {8'd0, dout}, 16'h005A);
    avail = 1'b0;
    tick();
    check("s2_wr_lo", {15'd0, wr}, 16'd0);
    tick(); tick(); tick();
    check("s2_ready", {15'd0, busy}, 16'd0);

    // Back-to-back from reset
    do_reset();
    avail = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      din = 8'(b);
      tick();
      check("s3_rd", {15'd0, rd}, 16'd1);
      check("s3_out", {8'd0, dout}, 16'(b));
      if (b == 3) avail = 1'b0;
      din = 8'hEE;
      tick();
      check("s3_wr_lo", {15'd0, wr}, 16'd0);
      fall_t[b-1] = cyc;
      tick(); tick();
      check("s3_wr_hi", {15'd0, wr}, 16'd1);
      tick();
    end
    check("s3_period_a", 16'(fall_t[1] - fall_t[0]), 16'd5);
    check("s3_period_b", 16'(fall_t[2] - fall_t[1]), 16'd5);
    check("s3_idle", {15'd0, busy}, 16'd0);
`ifdef WRITERESPONSE_BYTE_COUNT_EN
    check("s3_count", cnt1, 16'd3);
`endif

    // Reset in the middle of the strobe
    avail = 1'b1; din = 8'hC3;
    tick();
    avail = 1'b0;
    tick();
    check("s4_wr_lo", {15'd0, wr}, 16'd0);
    #3;
    nrst = 1'b0;
    #1;
    check("s4_wr_async", {15'd0, wr}, 16'd1);
    check("s4_out_async", {8'd0, dout}, 16'h0000);
    check("s4_busy_async", {15'd0, busy}, 16'd0);
    check("s4_rd_async", {15'd0, rd}, 16'd0);
`ifdef WRITERESPONSE_BYTE_COUNT_EN
    check("s4_count", cnt1, 16'd0);
`endif
    tick();
    nrst = 1'b1;
    tick();

    // WR_PULSE_CYCLES=1, HOLD_CYCLES=3: 6-cycle byte period
    avail2 = 1'b1; din2 = 8'h7E;
    tick();
    check("p_rd", {15'd0, rd2}, 16'd1);
    check("p_out", {8'd0, dout2}, 16'h007E);
    tick();
    check("p_wr_lo", {15'd0, wr2}, 16'd0);
    tick();
    check("p_wr_rise", {15'd0, wr2}, 16'd1);
    check("p_busy1", {15'd0, busy2}, 16'd1);
    tick();
    check("p_busy2", {15'd0, busy2}, 16'd1);
    tick();
    check("p_busy3", {15'd0, busy2}, 16'd1);
    check("p_rd_none", {15'd0, rd2}, 16'd0);
    tick();
    check("p_ready", {15'd0, busy2}, 16'd0);
    din2 = 8'h81;
    tick();
    check("p_rd2", {15'd0, rd2}, 16'd1);
    check("p_out2", {8'd0, dout2}, 16'h0081);
    avail2 = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("p_idle", {15'd0, busy2}, 16'd0);
    check("dut_untouched", {15'd0, busy}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
